// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter.
// Holds the FSM state encoding and parameter defaults.
package arbiter_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 4;
  localparam int IDX_W        = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G0   = 3'd1,
    G1   = 3'd2,
    G2   = 3'd3,
    G3   = 3'd4
  } state_t;

  // Gi is encoded as i+1 so IDLE can sit at zero.
  function automatic state_t grant_state(
    input logic [IDX_W-1:0] idx
  );
    return state_t'(3'(idx) + 3'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports: request (4b), start index -> valid, index of first set bit at/after start.
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [N_REQ_DEF-1:0] request,
  input  logic [IDX_W-1:0]     start,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);

  logic [2*N_REQ_DEF-1:0] dbl;
  logic [N_REQ_DEF-1:0]   rot;

  // Rotate so that bit 0 of rot is requester 'start'.
  always_comb begin
    dbl   = {request, request};
    rot   = dbl[start +: N_REQ_DEF];
    valid = |request;
    index = start;
    for (int k = N_REQ_DEF - 1; k >= 0; k--) begin
      if (rot[k]) index = start + IDX_W'(k);
    end
  end

endmodule

// File: rtl/arbiter.sv
// Moore round-robin arbiter with a per-grant hold limit.
// Ports: clock, reset (async, low), request[3:0] -> grant[3:0] (one-hot or zero).
module arbiter
  import arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] request,
  output logic [N_REQ-1:0] grant
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [HW-1:0]    hold;

  logic             legal;
  logic             busy;
  logic [2:0]       sv;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] start;
  logic [N_REQ-1:0] own;
  logic             others;
  logic             keep;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    sv     = state;
    legal  = (sv <= 3'd4);
    busy   = legal && (sv != 3'd0);
    cur    = IDX_W'(sv - 3'd1);
    // Searching from cur+1 visits cur last, so it
    // is only re-picked when nobody else asks.
    start  = busy ? cur + 2'd1 : last + 2'd1;
    own    = N_REQ'(1) << cur;
    others = |(request & ~own);
    keep   = busy && request[cur] &&
             ((hold < HOLD_LIM) || !others);
  end

  rr_pick u_pick (
    .request (request),
    .start   (start),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 2'd3;
      hold  <= '0;
    end else if (!legal) begin
      state <= IDLE;
      hold  <= '0;
    end else if (keep) begin
      if (hold < HOLD_LIM) hold <= hold + 1'b1;
    end else if (pick_valid) begin
      state <= grant_state(pick_idx);
      last  <= pick_idx;
      hold  <= '0;
    end else begin
      state <= IDLE;
      hold  <= '0;
    end
  end

  always_comb begin
    grant = '0;
    unique case (state)
      G0:      grant[0] = 1'b1;
      G1:      grant[1] = 1'b1;
      G2:      grant[2] = 1'b1;
      G3:      grant[3] = 1'b1;
      default: grant = '0;
    endcase
  end

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for the round-robin arbiter.
// Directed steps plus random traffic against a reference model.
module tb_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] request = 4'b0000;
  logic [3:0] grant;

  int checks = 0;
  int passed = 0;

  int m_cur  = -1;
  int m_last = 3;
  int m_hold = 0;

  arbiter #(.N_REQ(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clock   (clock),
    .reset   (reset),
    .request (request),
    .grant   (grant)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] m_grant();
    if (m_cur < 0) return 4'b0000;
    return 4'(1 << m_cur);
  endfunction

  function automatic int first_from(input logic [3:0] r, input int s);
    for (int k = 0; k < 4; k++) begin
      if (r[(s + k) % 4]) return (s + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_cur  = -1;
    m_last = 3;
    m_hold = 0;
  endtask

  task automatic m_enter(input int j);
    if (j < 0) begin
      m_cur  = -1;
      m_hold = 0;
    end else begin
      m_cur  = j;
      m_last = j;
      m_hold = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] others;
    if (m_cur < 0) begin
      if (r != 4'b0000) m_enter(first_from(r, (m_last + 1) % 4));
    end else begin
      others = r & ~m_grant();
      if (r[m_cur] && (m_hold < MAX_HOLD - 1 || others == 4'b0000)) begin
        if (m_hold < MAX_HOLD - 1) m_hold++;
      end else begin
        m_enter(first_from(r & ~m_grant(), (m_cur + 1) % 4));
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic cyc(input logic [3:0] r);
    request = r;
    @(posedge clock);
    model_edge(r);
    #1;
    chk("model", grant, m_grant());
    chk("onehot", {3'b000, $onehot0(grant)}, 4'b0001);
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] exp;

    // reset held with all requests up
    m_reset();
    reset   = 1'b0;
    request = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant", grant, 4'b0000);
    #2;
    reset   = 1'b1;
    request = 4'b0000;
    cyc(4'b0000);
    chk("rst_idle", grant, 4'b0000);
    cyc(4'b0000);
    chk("rst_idle2", grant, 4'b0000);

    // single requests, one per cycle
    for (int i = 0; i < 4; i++) begin
      v = 4'(1 << i);
      cyc(v);
      chk("single", grant, v);
    end
    cyc(4'b0000);
    chk("single_rel", grant, 4'b0000);

    // contention 0011: 4x G0, 4x G1, back to G0
    for (int k = 0; k < 12; k++) begin
      cyc(4'b0011);
      exp = (k < 4) ? 4'b0001 : (k < 8) ? 4'b0010 : 4'b0001;
      chk("contend", grant, exp);
    end

    // release and handoff
    cyc(4'b0010);
    chk("hand_g1", grant, 4'b0010);
    cyc(4'b0110);
    chk("hand_hold", grant, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1100);
      chk("hand_g2", grant, 4'b0100);
    end
    cyc(4'b1100);
    chk("hand_g3", grant, 4'b1000);

    // wrap-around 3 -> 0
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1001);
      chk("wrap_g3", grant, 4'b1000);
    end
    cyc(4'b1001);
    chk("wrap_g0", grant, 4'b0001);

    // async reset in the middle of a grant
    cyc(4'b0100);
    chk("pre_async", grant, 4'b0100);
    #2;
    reset = 1'b0;
    #1;
    chk("async_drop", grant, 4'b0000);
    m_reset();
    #2;
    request = 4'b0100;
    reset   = 1'b1;
    cyc(4'b0100);
    chk("async_regrant", grant, 4'b0100);

    // random traffic, sticky so holds and limits get exercised
    v = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
      cyc(v);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
